hamming_loader: RTL and testbench

Front-end stage for the Hamming min/max core. It accepts the 64-byte operand set (32 16-bit words) as a valid/ready byte stream and writes it into the shared 256x8 data memory at addresses 0..63. It then pulses the core's `start`, waits for `done` under a watchdog, and reads result bytes 64 (min) and 65 (max) back from memory. It presents those results on a valid/ready output port.

---
 rtl/hamming_loader.sv | 200 ++++++++++++++++++++
 tb/tb_hamming_loader.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hamming_loader.sv
// hamming_loader: front end for the Hamming min/max core.
// Streams the operand bytes into the shared data memory, starts the core,
// waits for done under a watchdog, reads the min/max result bytes back and
// offers them on a valid/ready port.
//
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   in_valid/in_data/in_ready   operand byte stream (big-endian words)
//   mem_we/mem_addr/mem_wdata   data-memory write/address port
//   mem_rdata                   data-memory read data (one-cycle latency)
//   core_start/core_done        core handshake (start pulse, done level)
//   res_valid/res_min/res_max   result port, held until res_ready
//   busy                        high unless idle in LOAD with nothing loaded
//   err_timeout                 sticky watchdog flag
module hamming_loader #(
    parameter int unsigned N_WORDS     = 32,
    parameter int unsigned RESULT_ADDR = 64,
    parameter int unsigned TIMEOUT     = 4096
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       mem_we,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    input  logic [7:0] mem_rdata,
    output logic       core_start,
    input  logic       core_done,
    output logic       res_valid,
    output logic [4:0] res_min,
    output logic [4:0] res_max,
    input  logic       res_ready,
    output logic       busy,
    output logic       err_timeout
);

    localparam int unsigned ADDR_W  = 8;
    localparam int unsigned RES_W   = 5;
    localparam int unsigned N_BYTES = 2 * N_WORDS;
    localparam int unsigned WD_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_LOAD,
        S_START,
        S_WAIT,
        S_RD_MIN,
        S_RD_MAX,
        S_CAP,
        S_OUT
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [ADDR_W-1:0] byte_cnt;
    logic [WD_W-1:0]   wd_cnt;
    logic              seen_low;

    // control strobes from the FSM to the datapath registers
    logic cnt_inc;
    logic cnt_clr;
    logic wd_clr;
    logic wd_inc;
    logic seen_set;
    logic cap_min;
    logic cap_max;
    logic set_err;

    // result bytes only carry five meaningful bits
    logic rdata_hi_unused;
    assign rdata_hi_unused = ^mem_rdata[7:RES_W];

    assign busy = !((state == S_LOAD) && (byte_cnt == '0));

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_LOAD;
        end else begin
            state <= state_n;
        end
    end

    // next state, memory/core/result port decode and datapath strobes
    always_comb begin
        state_n    = state;
        in_ready   = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        core_start = 1'b0;
        res_valid  = 1'b0;
        cnt_inc    = 1'b0;
        cnt_clr    = 1'b0;
        wd_clr     = 1'b0;
        wd_inc     = 1'b0;
        seen_set   = 1'b0;
        cap_min    = 1'b0;
        cap_max    = 1'b0;
        set_err    = 1'b0;
        unique case (state)
            S_LOAD: begin
                in_ready = 1'b1;
                mem_addr = byte_cnt;
                // reset gates the write so a held in_valid cannot write during reset
                if (in_valid && !reset) begin
                    mem_we    = 1'b1;
                    mem_wdata = in_data;
                    if (byte_cnt == ADDR_W'(N_BYTES - 1)) begin
                        cnt_clr = 1'b1;
                        state_n = S_START;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            S_START: begin
                core_start = 1'b1;
                wd_clr     = 1'b1;
                state_n    = S_WAIT;
            end
            S_WAIT: begin
                if (!core_done) begin
                    seen_set = 1'b1;
                end
                // done only counts after it has been seen low since the start pulse
                if (core_done && seen_low) begin
                    state_n = S_RD_MIN;
                end else if (wd_cnt == WD_W'(TIMEOUT - 1)) begin
                    set_err = 1'b1;
                    state_n = S_LOAD;
                end else begin
                    wd_inc = 1'b1;
                end
            end
            S_RD_MIN: begin
                mem_addr = ADDR_W'(RESULT_ADDR);
                state_n  = S_RD_MAX;
            end
            S_RD_MAX: begin
                mem_addr = ADDR_W'(RESULT_ADDR + 1);
                cap_min  = 1'b1;
                state_n  = S_CAP;
            end
            S_CAP: begin
                cap_max = 1'b1;
                state_n = S_OUT;
            end
            S_OUT: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_n = S_LOAD;
                end
            end
            default: begin
                state_n = S_LOAD;
            end
        endcase
    end

    // byte counter, watchdog, done qualifier, result and error registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byte_cnt    <= '0;
            wd_cnt      <= '0;
            seen_low    <= 1'b0;
            res_min     <= '0;
            res_max     <= '0;
            err_timeout <= 1'b0;
        end else begin
            if (cnt_clr) begin
                byte_cnt <= '0;
            end else if (cnt_inc) begin
                byte_cnt <= byte_cnt + ADDR_W'(1);
            end
            if (wd_clr) begin
                wd_cnt   <= '0;
                seen_low <= 1'b0;
            end else begin
                if (wd_inc) begin
                    wd_cnt <= wd_cnt + WD_W'(1);
                end
                if (seen_set) begin
                    seen_low <= 1'b1;
                end
            end
            if (cap_min) begin
                res_min <= mem_rdata[RES_W-1:0];
            end
            if (cap_max) begin
                res_max <= mem_rdata[RES_W-1:0];
            end
            if (set_err) begin
                err_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hamming_loader.sv
// Bench for hamming_loader: directed runs checked every cycle against a
// phase-level model, plus literal expectations at key points.
module tb_hamming_loader;

    localparam int unsigned NW = 32;
    localparam int unsigned RA = 64;
    localparam int unsigned TO = 16;
    localparam int unsigned NB = 2 * NW;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       core_start;
    logic       core_done;
    logic       res_valid;
    logic [4:0] res_min;
    logic [4:0] res_max;
    logic       res_ready;
    logic       busy;
    logic       err_timeout;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    hamming_loader #(.N_WORDS(NW), .RESULT_ADDR(RA), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .core_start(core_start), .core_done(core_done),
        .res_valid(res_valid), .res_min(res_min), .res_max(res_max),
        .res_ready(res_ready), .busy(busy), .err_timeout(err_timeout)
    );

    // data memory: operand area is real storage, result bytes come from the core model
    logic [7:0] mem [0:255];
    logic [7:0] r_lo;
    logic [7:0] r_hi;
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_addr == 8'(RA))          mem_rdata <= r_lo;
        else if (mem_addr == 8'(RA + 1)) mem_rdata <= r_hi;
        else                             mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // operand words; byte 2k is the high byte of word k
    function automatic logic [15:0] wval(input int run, input int k);
        return 16'((k * 1031 + run * 7919 + 3) & 32'hFFFF);
    endfunction

    function automatic logic [7:0] sbyte(input int run, input int i);
        logic [15:0] w;
        w = wval(run, i / 2);
        return (i % 2 == 0) ? w[15:8] : w[7:0];
    endfunction

    // ---------------- behavioural model (phase level) ----------------
    localparam int P_LOAD = 0, P_START = 1, P_WAIT = 2, P_POST = 3, P_OUT = 4;
    int         m_ph, m_cnt, m_wcyc, m_post;
    bit         m_seen, m_err;
    logic [4:0] m_min, m_max;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_ph <= P_LOAD; m_cnt <= 0; m_wcyc <= 0; m_post <= 0;
            m_seen <= 1'b0; m_err <= 1'b0; m_min <= '0; m_max <= '0;
        end else begin
            case (m_ph)
                P_LOAD: if (in_valid) begin
                    if (m_cnt == NB - 1) begin m_cnt <= 0; m_ph <= P_START; end
                    else m_cnt <= m_cnt + 1;
                end
                P_START: begin m_seen <= 1'b0; m_wcyc <= 0; m_ph <= P_WAIT; end
                P_WAIT: begin
                    if (core_done && m_seen) begin
                        m_ph <= P_POST; m_post <= 1;
                    end else begin
                        m_seen <= m_seen || !core_done;
                        if (m_wcyc + 1 == TO) begin m_err <= 1'b1; m_ph <= P_LOAD; end
                        else m_wcyc <= m_wcyc + 1;
                    end
                end
                P_POST: begin
                    if (m_post == 2) m_min <= r_lo[4:0];
                    if (m_post == 3) begin m_max <= r_hi[4:0]; m_ph <= P_OUT; end
                    m_post <= m_post + 1;
                end
                P_OUT: if (res_ready) m_ph <= P_LOAD;
                default: m_ph <= P_LOAD;
            endcase
        end
    end

    // per-cycle comparison against the model
    bit         e_ld, e_acc;
    logic [7:0] e_addr;
    always @(negedge clk) begin
        if (chk_en) begin
            e_ld  = (m_ph == P_LOAD);
            e_acc = e_ld && in_valid && !reset;
            if (e_ld)                           e_addr = 8'(m_cnt);
            else if (m_ph == P_POST && m_post == 1) e_addr = 8'(RA);
            else if (m_ph == P_POST && m_post == 2) e_addr = 8'(RA + 1);
            else                                e_addr = 8'h00;
            chk("in_ready", in_ready, e_ld);
            chk("mem_we", mem_we, e_acc);
            chk("mem_addr", mem_addr, e_addr);
            chk("mem_wdata", mem_wdata, e_acc ? in_data : 8'h00);
            chk("core_start", core_start, m_ph == P_START);
            chk("res_valid", res_valid, m_ph == P_OUT);
            chk("res_min", res_min, m_min);
            chk("res_max", res_max, m_max);
            chk("busy", busy, !(e_ld && m_cnt == 0));
            chk("err_timeout", err_timeout, m_err);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk); #1;
    endtask

    // returns in the START cycle; gap inserts an idle cycle between bytes
    task automatic load_run(input int run, input bit gap);
        for (int i = 0; i < NB; i++) begin
            in_valid = 1'b1;
            in_data  = sbyte(run, i);
            step();
            if (gap && i < NB - 1) begin
                in_valid = 1'b0;
                in_data  = 8'hAA;
                step();
            end
        end
        in_valid = 1'b0;
        in_data  = 8'h00;
        chk("start_after_last", core_start, 1);
    endtask

    task automatic check_mem(input int run);
        int bad;
        logic [15:0] w;
        bad = 0;
        for (int k = 0; k < NW; k++) begin
            w = wval(run, k);
            if (mem[2*k] !== w[15:8] || mem[2*k+1] !== w[7:0]) bad++;
        end
        chk("mem_words_bad", bad, 0);
    endtask

    task automatic wait_result(input int exp_lat, input string nm);
        int n;
        n = 0;
        while (!res_valid && n < 20) begin step(); n++; end
        chk(nm, n, exp_lat);
    endtask

    task automatic handshake();
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        chk("after_hs_valid", res_valid, 0);
        chk("after_hs_ready", in_ready, 1);
    endtask

    bit saw_valid;

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = 8'h00;
        core_done = 1'b0; res_ready = 1'b0; r_lo = 8'h00; r_hi = 8'h00;
        step(); step();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_res_valid", res_valid, 0);
        reset = 1'b0;
        chk_en = 1'b1;

        // full-rate load, normal completion, backpressure
        r_lo = 8'd3; r_hi = 8'd12;
        in_valid = 1'b1; in_data = sbyte(1, 0);
        #1 chk("first_write_addr", mem_addr, 0);
        load_run(1, 1'b0);
        check_mem(1);
        step();
        chk("start_one_cycle", core_start, 0);
        repeat (8) step();
        core_done = 1'b1;
        wait_result(4, "res_latency_normal");
        for (int i = 0; i < 5; i++) begin
            chk("bp_min", res_min, 3);
            chk("bp_max", res_max, 12);
            chk("bp_valid", res_valid, 1);
            step();
        end
        handshake();

        // back-to-back load with done left high: watchdog must fire
        load_run(2, 1'b0);
        check_mem(2);
        saw_valid = 1'b0;
        for (int i = 0; i < TO; i++) begin
            step();
            saw_valid = saw_valid | res_valid;
        end
        chk("wd_not_yet", err_timeout, 0);
        step();
        chk("wd_fired", err_timeout, 1);
        chk("wd_in_ready", in_ready, 1);
        chk("wd_no_result", saw_valid | res_valid, 0);

        // gapped load, truncation of result bytes, input ignored while busy
        r_lo = 8'hE5; r_hi = 8'h30;
        core_done = 1'b0;
        load_run(3, 1'b1);
        check_mem(3);
        in_valid = 1'b1; in_data = 8'h5A;
        repeat (3) step();
        core_done = 1'b1;
        wait_result(4, "res_latency_trunc");
        in_valid = 1'b0;
        chk("trunc_min", res_min, 5);
        chk("trunc_max", res_max, 16);
        handshake();

        // asynchronous reset after byte 20
        core_done = 1'b0;
        for (int i = 0; i <= 20; i++) begin
            in_valid = 1'b1; in_data = sbyte(4, i);
            step();
        end
        in_data = 8'h77;
        reset = 1'b1;
        #1;
        chk("arst_in_ready", in_ready, 1);
        chk("arst_mem_we", mem_we, 0);
        chk("arst_mem_addr", mem_addr, 0);
        chk("arst_mem_wdata", mem_wdata, 0);
        chk("arst_core_start", core_start, 0);
        chk("arst_res_valid", res_valid, 0);
        chk("arst_res_min", res_min, 0);
        chk("arst_res_max", res_max, 0);
        chk("arst_busy", busy, 0);
        chk("arst_err", err_timeout, 0);
        step();
        reset = 1'b0;
        in_data = sbyte(5, 0);
        #1;
        chk("post_rst_addr", mem_addr, 0);
        chk("post_rst_we", mem_we, 1);

        // reload after reset with extreme result values
        r_lo = 8'h1F; r_hi = 8'h00;
        load_run(5, 1'b0);
        check_mem(5);
        repeat (2) step();
        core_done = 1'b1;
        wait_result(4, "res_latency_final");
        chk("final_min", res_min, 31);
        chk("final_max", res_max, 0);
        handshake();
        repeat (3) step();

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench time limit");
    end

endmodule
